mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
// - Sequences data-memory loads/stores issued by the MEM pipeline stage over a req/gnt/rvalid bus.
// - Generates byte enables and store-data lane replication; sign/zero-extends load data.
// - Stalls the pipeline while an access is in flight and flags misaligned or illegal accesses.
// - Sits between the MEM stage control signals and the data memory. Its formatted load data feeds the WB mux.
// PARAMETERS
// - ADDR_W       32  byte-address width; dmem_addr_o is word-aligned (bits [1:0] forced to 0)
// - TIMEOUT_CYC  16  watchdog limit in cycles; used only with MEM_ACCESS_TIMEOUT_EN
// PORTS
// - clk            in   1       clock, rising edge
// - rst_n          in   1       asynchronous reset, active low
// - mem_read_i     in   1       MEM stage holds a load
// - mem_write_i    in   1       MEM stage holds a store (mutually exclusive with mem_read_i)
// - funct3_i       in   3       access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
// - addr_i         in   ADDR_W  effective byte address (ALU result)
// - wdata_i        in   32      store data (rs2)
// - flush_i        in   1       kill the current access result (pipeline flush)
// - dmem_req_o     out  1       bus request, held until dmem_gnt_i
// - dmem_we_o      out  1       1 = write
// - dmem_addr_o    out  ADDR_W  word-aligned address
// - dmem_be_o      out  4       byte enables
// - dmem_wdata_o   out  32      lane-replicated store data
// - dmem_gnt_i     in   1       request accepted this cycle
// - dmem_rvalid_i  in   1       read data valid, at least 1 cycle after gnt
// - dmem_rdata_i   in   32      raw read word
// - stall_o        out  1       hold the IF..MEM stages
// - load_valid_o   out  1       1-cycle pulse; load_data_o valid
// - load_data_o    out  32      extended load result
// - access_fault_o out  1       1-cycle pulse: misaligned or illegal funct3
// - bus_err_o      out  1       1-cycle pulse on watchdog timeout (tied 0 without the macro)
// BEHAVIOUR
// - Reset: state IDLE. All outputs 0, including dmem_* and load_data_o.
// - FSM states: IDLE, REQ, WAIT, DONE.
//   - IDLE -> REQ: on a legal access.
//   - REQ -> WAIT: gnt with load.
//   - REQ -> DONE: gnt with store.
//   - WAIT -> DONE: on rvalid.
//   - DONE -> IDLE: always.
// - Bus-side outputs are registered.
//   - dmem_req_o/we/addr/be/wdata are set on the IDLE->REQ edge.
//   - They stay stable while in REQ; dmem_req_o drops on the edge after gnt.
// - stall_o (combinational) = (IDLE & legal access) | REQ | WAIT. It is low in DONE, so the pipeline advances.
// - Minimum stall cycles:
//   - Load: 3 (IDLE, REQ with gnt, WAIT with rvalid).
//   - Store: 2.
// - load_valid_o / load_data_o are registered at WAIT->DONE and are high only in DONE.
// - Byte enables and store lanes:
//   - SB: be = 4'b0001 << addr[1:0]; wdata = {4{wdata_i[7:0]}}.
//   - SH: be = 4'b0011 << {addr[1],1'b0}; wdata = {2{wdata_i[15:0]}}.
//   - SW: be = 4'hF.
//   - Loads drive be = 4'hF.
// - Load extraction: select the byte/half by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
// - Fault conditions (no bus request, no stall; access_fault_o pulses the next cycle, once per instruction):
//   - Half access with addr[0] = 1.
//   - Word access with addr[1:0] != 0.
//   - Illegal funct3: 3'b011, 3'b110 or 3'b111 for loads; >= 3'b011 for stores.
// - flush_i behaviour:
//   - In IDLE: no access starts.
//   - In REQ: the request stays up until gnt, because the bus handshake is never abandoned.
//   - In REQ or WAIT: the outstanding response is still consumed. load_valid_o stays 0 in DONE.
//   - stall_o stays asserted until the handshake completes.
// - Simultaneous gnt and rvalid in REQ is illegal on this bus; the bench asserts it never occurs.
// - Reset mid-access returns to IDLE immediately. The memory side must tolerate a dropped request.
// CONFIGURATION
// - MEM_ACCESS_TIMEOUT_EN defined:
//   - A counter clears on IDLE->REQ and counts each cycle in REQ/WAIT.
//   - At TIMEOUT_CYC it forces DONE with load_valid_o = 0 and pulses bus_err_o.
//   - Counter width is $clog2(TIMEOUT_CYC+1).
// - MEM_ACCESS_TIMEOUT_EN undefined: no counter; bus_err_o is constant 0; the FSM can wait indefinitely.
// STRUCTURE
// - defines.v holds:
//   - FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW.
//   - State encodings MAC_IDLE/MAC_REQ/MAC_WAIT/MAC_DONE (2-bit).
// - Sub-module load_formatter (combinational): rdata, addr[1:0], funct3 -> load_data. It is reused by the WB-side debug path.
// - The FSM, byte-enable/lane logic and the watchdog stay in this module.
// TESTING
// - LW @0x100, gnt in REQ, rvalid the next cycle, rdata=0xDEADBEEF:
//   - stall_o high for 3 cycles.
//   - load_valid_o pulses with load_data_o=0xDEADBEEF.
// - LB @0x103, rdata=0x80FF_0000 -> load_data_o=0xFFFFFF80. The same access with LBU -> 0x00000080.
// - SH @0x102, wdata=0x1234ABCD, gnt delayed 2 cycles:
//   - be=4'b1100, wdata=0xABCDABCD.
//   - req held 3 cycles; stall_o high for 4 cycles.
// - LW @0x101 -> no dmem_req_o, stall_o never high, access_fault_o one pulse.
// - flush_i asserted in WAIT -> rvalid is still consumed, load_valid_o stays 0, FSM returns to IDLE.
// - With MEM_ACCESS_TIMEOUT_EN, no gnt for 16 cycles -> bus_err_o pulses, stall_o drops, FSM returns to IDLE.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: funct3 codes, FSM states, lane helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mem_access_ctrl_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    MAC_IDLE = 2'd0,
    MAC_REQ  = 2'd1,
    MAC_WAIT = 2'd2,
    MAC_DONE = 2'd3
  } mac_state_t;

  // Illegal size/sign code or an address not naturally aligned to the access size.
  function automatic logic access_bad(input logic is_store, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic bad;
    if (is_store) bad = funct3[2] | (funct3[1:0] == 2'b11);
    else          bad = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
    case (funct3[1:0])
      2'b01:   if (addr_lo[0]) bad = 1'b1;
      2'b10:   if (addr_lo != 2'b00) bad = 1'b1;
      default: ;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = 4'b0011 << {addr_lo[1], 1'b0};
      default: be = 4'hF;
    endcase
    return be;
  endfunction

  // Replicate the narrow store value across every lane so the byte enables pick the right copy.
  function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] wdata);
    logic [31:0] d;
    case (funct3[1:0])
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_formatter.sv
// Extracts the addressed byte/half/word from a raw read word and sign- or zero-extends it.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
module mem_access_ctrl_load_formatter
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Move the addressed lane down to bit 0, then extend according to funct3.
  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (funct3)
      FUNCT3_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      FUNCT3_LH:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      FUNCT3_LW:  load_data = rdata;
      FUNCT3_LBU: load_data = {24'h0, shifted[7:0]};
      FUNCT3_LHU: load_data = {16'h0, shifted[15:0]};
      default:    load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences MEM-stage loads/stores over a req/gnt/rvalid bus; faults misaligned/illegal accesses.
// Latency: load >= 3 stall cycles (result in DONE), store >= 2; fault pulses the cycle after.
// Backpressure: stall_o holds IF..MEM until the handshake completes; optional watchdog MEM_ACCESS_TIMEOUT_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              flush_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic              stall_o,
  output logic              load_valid_o,
  output logic [31:0]       load_data_o,
  output logic              access_fault_o,
  output logic              bus_err_o
);

  mac_state_t  state_q, state_d;
  logic        access, bad, start, in_flight, timeout_fire, kill_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [31:0] fmt_data;

  assign access    = mem_read_i | mem_write_i;
  assign bad       = access_bad(mem_write_i, funct3_i, addr_i[1:0]);
  assign start     = (state_q == MAC_IDLE) & access & ~bad & ~flush_i;
  assign in_flight = (state_q == MAC_REQ) | (state_q == MAC_WAIT);
  assign stall_o   = start | in_flight;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MAC_IDLE;
    else        state_q <= state_d;
  end

  // Next state: handshake progress wins over a coincident watchdog expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MAC_IDLE: if (start) state_d = MAC_REQ;
      MAC_REQ:  if (dmem_gnt_i) state_d = dmem_we_o ? MAC_DONE : MAC_WAIT;
                else if (timeout_fire) state_d = MAC_DONE;
      MAC_WAIT: if (dmem_rvalid_i || timeout_fire) state_d = MAC_DONE;
      MAC_DONE: state_d = MAC_IDLE;
      default:  state_d = MAC_IDLE;
    endcase
  end

  // Bus request fields are captured once at issue and held; req drops after gnt or watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= 4'h0;
      dmem_wdata_o <= 32'h0;
      f3_q         <= 3'b000;
      lo_q         <= 2'b00;
    end else if (start) begin
      dmem_req_o   <= 1'b1;
      dmem_we_o    <= mem_write_i;
      dmem_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
      dmem_be_o    <= mem_write_i ? store_be(funct3_i, addr_i[1:0]) : 4'hF;
      dmem_wdata_o <= mem_write_i ? store_wdata(funct3_i, wdata_i) : 32'h0;
      f3_q         <= funct3_i;
      lo_q         <= addr_i[1:0];
    end else if ((state_q == MAC_REQ) && (dmem_gnt_i || timeout_fire)) begin
      dmem_req_o   <= 1'b0;
    end
  end

  // A flush during the handshake only suppresses the result; the response is still consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   kill_q <= 1'b0;
    else if (start)               kill_q <= 1'b0;
    else if (in_flight & flush_i) kill_q <= 1'b1;
  end

  mem_access_ctrl_load_formatter u_fmt (
    .rdata     (dmem_rdata_i),
    .addr_lo   (lo_q),
    .funct3    (f3_q),
    .load_data (fmt_data)
  );

  // Load result is registered on WAIT->DONE so it is visible exactly in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_valid_o <= 1'b0;
      load_data_o  <= 32'h0;
    end else if ((state_q == MAC_WAIT) && dmem_rvalid_i && !(kill_q || flush_i)) begin
      load_valid_o <= 1'b1;
      load_data_o  <= fmt_data;
    end else begin
      load_valid_o <= 1'b0;
    end
  end

  // Faulting accesses never reach the bus; the pulse comes one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) access_fault_o <= 1'b0;
    else        access_fault_o <= (state_q == MAC_IDLE) & access & bad & ~flush_i;
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wd_cnt_q;
  logic             progress;

  assign progress     = ((state_q == MAC_REQ) & dmem_gnt_i) | ((state_q == MAC_WAIT) & dmem_rvalid_i);
  assign timeout_fire = in_flight & ~progress & (wd_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Watchdog counts every REQ/WAIT cycle of the current access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         wd_cnt_q <= '0;
    else if (start)     wd_cnt_q <= '0;
    else if (in_flight) wd_cnt_q <= wd_cnt_q + 1'b1;
  end

  // Bus error pulses in the forced DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus_err_o <= 1'b0;
    else        bus_err_o <= timeout_fire;
  end
`else
  localparam int timeout_unused = TIMEOUT_CYC;
  assign timeout_fire = 1'b0;
  assign bus_err_o    = 1'b0;
`endif

endmodule
